// File: rtl/seq_addsub_pkg.sv
// Shared types and elaboration helpers for the chunked sequential adder/subtractor.
// The state encoding is kept as plain constants so older flows can consume it unchanged.
package seq_addsub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic int calc_n(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int calc_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit chunk_fits(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/seq_addsub_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
// Zero latency; no flow control, the parent sequences it one chunk per clock.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x_i,
    input  logic [CHUNK-1:0] y_i,
    input  logic             c_in_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             c_out_o
);

    logic [CHUNK:0] c;

    assign c[0] = c_in_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum_o[i] = x_i[i] ^ y_i[i] ^ c[i];
        assign c[i+1]   = (x_i[i] & y_i[i]) | (c[i] & (x_i[i] ^ y_i[i]));
    end

    assign c_out_o = c[CHUNK];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle WIDTH-bit add/sub through one shared CHUNK-bit ripple stage; done pulses N+1 cycles after start.
// start is only taken in IDLE or DONE; a start during RUN is dropped, so callers must wait for done.
module seq_addsub
    import seq_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_out_o,
    output logic             ovf_o
);

    localparam int N     = calc_n(WIDTH, CHUNK);
    localparam int CNT_W = calc_cnt_w(N);

    if (!chunk_fits(WIDTH, CHUNK)) begin : g_bad_params
        $error("seq_addsub: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;

    logic [CHUNK-1:0]   chunk_sum;
    logic               chunk_cout;
    logic [WIDTH-1:0]   sh_next;
    logic               accept;
    logic               last;

    // Operand registers shift right each RUN cycle so the active chunk is always the low bits.
    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .x_i     (a_q[CHUNK-1:0]),
        .y_i     (b_q[CHUNK-1:0]),
        .c_in_i  (carry_q),
        .sum_o   (chunk_sum),
        .c_out_o (chunk_cout)
    );

    assign sh_next = (sh_q >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));
    assign accept  = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last    = (cnt_q == CNT_W'(N - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_RUN;
            ST_RUN:  if (last)    state_d = ST_DONE;
            ST_DONE: state_d = start_i ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            a_d     = a_i;
            b_d     = sub_i ? ~b_i : b_i;
            a_msb_d = a_i[WIDTH-1];
            b_msb_d = sub_i ? ~b_i[WIDTH-1] : b_i[WIDTH-1];
            carry_d = sub_i ^ c_in_i;
            cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            carry_d = chunk_cout;
            sh_d    = sh_next;
            // Counter parks on N-1 rather than wrapping; accept clears it.
            if (!last) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (last) begin
                sum_d   = sh_next;
                c_out_d = chunk_cout;
                ovf_d   = (a_msb_q == b_msb_q) && (sh_next[WIDTH-1] != a_msb_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy_o  = (state_q == ST_RUN);
    assign done_o  = (state_q == ST_DONE);
    assign sum_o   = sum_q;
    assign c_out_o = c_out_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed bench for seq_addsub at WIDTH=16, CHUNK=4 (four busy cycles, done in the fifth).
module tb_seq_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        sub_i;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        c_in_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] sum_o;
    logic        c_out_o;
    logic        ovf_o;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    seq_addsub #(
        .WIDTH (16),
        .CHUNK (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .sub_i   (sub_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .c_in_i  (c_in_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .sum_o   (sum_o),
        .c_out_o (c_out_o),
        .ovf_o   (ovf_o)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic drive(input logic st, input logic sb, input logic [15:0] a,
                         input logic [15:0] b, input logic ci);
        start_i = st;
        sub_i   = sb;
        a_i     = a;
        b_i     = b;
        c_in_i  = ci;
    endtask

    task automatic check_ctrl(input string name, input logic exp_busy, input logic exp_done);
        n_total++;
        if (busy_o !== exp_busy || done_o !== exp_done)
            $display("FAIL %s: busy/done got %b/%b expected %b/%b", name, busy_o, done_o, exp_busy, exp_done);
        else
            n_pass++;
    endtask

    task automatic check_res(input string name, input logic [15:0] es, input logic ec, input logic eo);
        n_total++;
        if (sum_o !== es || c_out_o !== ec || ovf_o !== eo)
            $display("FAIL %s: sum/c_out/ovf got %h/%b/%b expected %h/%b/%b",
                     name, sum_o, c_out_o, ovf_o, es, ec, eo);
        else
            n_pass++;
    endtask

    // start in cycle 0, expect busy in cycles 1..4, done plus result in cycle 5.
    task automatic run_op(input string name, input logic sb, input logic [15:0] a,
                          input logic [15:0] b, input logic ci, input logic [15:0] es,
                          input logic ec, input logic eo);
        drive(1'b1, sb, a, b, ci);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_ctrl({name, "_busy"}, 1'b1, 1'b0);
            @(negedge clk);
        end
        check_ctrl({name, "_done"}, 1'b0, 1'b1);
        check_res(name, es, ec, eo);
        @(negedge clk);
        check_ctrl({name, "_idle"}, 1'b0, 1'b0);
        check_res({name, "_hold"}, es, ec, eo);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_ctrl("reset_ctrl", 1'b0, 1'b0);
        check_res("reset_res", 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_add();
        run_op("add_basic", 1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("add_carry", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_ovf",   1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("add_cin",   1'b0, 16'h00FF, 16'h0F00, 1'b1, 16'h1000, 1'b0, 1'b0);
    endtask

    task automatic test_sub();
        run_op("sub_neg",  1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf",  1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        run_op("sub_bin",  1'b1, 16'h0010, 16'h0003, 1'b1, 16'h000C, 1'b1, 1'b0);
    endtask

    task automatic test_start_in_run();
        drive(1'b1, 1'b0, 16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b1, 16'hABCD, 16'h1357, 1'b1);
        check_ctrl("ignore_busy", 1'b1, 1'b0);
        @(negedge clk);
        check_ctrl("ignore_busy4", 1'b1, 1'b0);
        @(negedge clk);
        check_ctrl("ignore_done", 1'b0, 1'b1);
        check_res("ignore_res", 16'h3333, 1'b0, 1'b0);
        @(negedge clk);
        check_ctrl("ignore_idle", 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        logic seen_done;
        seen_done = 1'b0;
        drive(1'b1, 1'b0, 16'hAAAA, 16'h5555, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_ctrl("abort_idle", 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (done_o === 1'b1) seen_done = 1'b1;
            @(negedge clk);
        end
        n_total++;
        if (seen_done !== 1'b0)
            $display("FAIL abort_no_done: done seen %b expected %b", seen_done, 1'b0);
        else
            n_pass++;
        check_res("abort_res", 16'h0000, 1'b0, 1'b0);
        run_op("after_abort", 1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 16'h0F0F, 16'h0101, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (4) @(negedge clk);
        check_ctrl("b2b_done1", 1'b0, 1'b1);
        check_res("b2b_res1", 16'h1010, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'h1000, 16'h0001, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_ctrl("b2b_busy2", 1'b1, 1'b0);
            @(negedge clk);
        end
        check_ctrl("b2b_done2", 1'b0, 1'b1);
        check_res("b2b_res2", 16'h0FFF, 1'b1, 1'b0);
        @(negedge clk);
        check_ctrl("b2b_idle", 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        test_reset();
        test_add();
        test_sub();
        test_start_in_run();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_addsub.md
# seq_addsub

Parametrised multi-cycle adder/subtractor. A WIDTH-bit operation is processed CHUNK bits per clock through one shared CHUNK-bit ripple stage, with a start/busy/done handshake. It extends the lab's fixed 4-bit combinational ripple adder with operand width, chunk size, subtract mode, signed-overflow detection and registered results. It sits in the arithmetic-circuits lab set and is the datapath block for later sequential ALU exercises.

## Interface
- WIDTH, 16: operand and result width. Must be a multiple of CHUNK.
- CHUNK, 4: bits processed per cycle. N = WIDTH/CHUNK cycles per operation. CHUNK = WIDTH is legal (N = 1).
- clk  in  1  clock. All state changes on the rising edge.
- rst  in  1  reset. Synchronous, active-high.
- start  in  1  request. Sampled only in IDLE or DONE.
- sub  in  1  mode. 0 = add, 1 = subtract. Latched with start.
- a  in  WIDTH  operand A. Latched with start.
- b  in  WIDTH  operand B. Latched with start.
- c_in  in  1  carry-in (add) or borrow-in (sub). Latched with start.
- busy  out  1  high while chunks are being processed (RUN).
- done  out  1  one-cycle completion pulse.
- sum  out  WIDTH  registered result.
- c_out  out  1  raw carry out of the MSB. For sub: 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.

## Operation
- **States:**
  - IDLE: start → RUN.
  - RUN: after the N-th chunk → DONE.
  - DONE: start → RUN; else → IDLE.
- **On accept:**
  - Latch A.
  - Latch B' = sub ? ~b : b.
  - Set carry = sub ? ~c_in : c_in.
  - Clear the chunk counter.
- **Subtract result:** sub computes a − b − c_in as a + ~b + ~c_in.
- **Each RUN cycle:**
  - Chunk i (LSB chunk first) = A[i*CHUNK +: CHUNK] + B'[same] + carry.
  - The result chunk shifts into the MSB end of an internal WIDTH-bit shift register (right shift by CHUNK).
  - The chunk carry-out becomes the next carry.
  - The counter increments.
- **On the last chunk (counter = N−1):**
  - sum ← completed shift-register value.
  - c_out ← final carry.
  - ovf ← (A[MSB] == B'[MSB]) && (result[MSB] != A[MSB]).
- **Output stability:** sum, c_out and ovf change only on completion or reset. They hold their values until the next completion.
- **start during RUN:** ignored. Latched operands are unaffected by input changes after acceptance.
- **start in DONE:** accepted (back-to-back operation).
- **rst mid-operation:** abort and go to IDLE. No done pulse for the aborted operation.
- **Reset values:** state IDLE, busy 0, done 0, sum 0, c_out 0, ovf 0, counter 0, carry 0.

## Timing
- start high in cycle 0 (accepted) → busy high in cycles 1..N → done high in cycle N+1 only.
- sum, c_out and ovf are valid from cycle N+1 onward.
- Latency from start to done is N+1 cycles. Throughput is one operation per N+1 cycles with back-to-back start.
- With N = 1: busy is high one cycle, done in cycle 2.
- Counter width is max(1, $clog2(N)). The counter never wraps inside an operation, and it is cleared on accept.
- No combinational path from inputs to outputs. All outputs come from registers.

## Structure
- Package seq_addsub_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - localparam helpers for N and counter width;
  - an elaboration check that WIDTH % CHUNK == 0.
- One sub-module, chunk_adder #(CHUNK): a combinational CHUNK-bit ripple of full-adder cells (x, y, c_in → sum, c_out), instantiated once.
- The top level holds the FSM, operand registers, carry register, shift register and output registers.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 (N=4).
- rst held 2 cycles, then released → busy=0, done=0, sum=0x0000, c_out=0, ovf=0.
- add 0x1234 + 0x4321, c_in=0, start in cycle 0 → busy cycles 1–4, done cycle 5, sum=0x5555, c_out=0, ovf=0.
- add 0xFFFF + 0x0001 → sum=0x0000, c_out=1, ovf=0.
- add 0x7FFF + 0x0001 → sum=0x8000, c_out=0, ovf=1.
- sub:
  - 0x0005 − 0x0007, c_in=0 → sum=0xFFFE, c_out=0, ovf=0.
  - 0x8000 − 0x0001 → sum=0x7FFF, c_out=1, ovf=1.
- Control:
  - Pulse start with new operands in cycle 2 of a RUN → ignored, original result delivered.
  - Assert rst in cycle 2 → IDLE next cycle with no done pulse, and a following add of 1 + 1 gives sum=0x0002.
  - start asserted in the DONE cycle → new operation accepted with no idle gap.
